// File: rtl/en_reg_arbiter_pkg.sv
// rtl/en_reg_arbiter_pkg.sv - shared constants and round-robin pick helper
package en_reg_arbiter_pkg;

   localparam int NREQ_D   = 4;
   localparam int NREG_D   = 4;
   localparam int WIDTH_D  = 8;
   localparam int ADDR_W_D = 2;

   // Widest requester vector the helper handles; callers zero-pad narrower ones.
   localparam int MAX_NREQ = 8;

   // Returns {found, index}: the first requester set when scanning from ptr
   // upward with wrap at nreq. Scanned backwards so the earliest hit is the
   // last one written. ptr < nreq always holds, so one subtraction wraps.
   function automatic logic [3:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                          input logic [2:0]          ptr,
                                          input int                  nreq);
      logic [3:0] res;
      int         idx;
      res = '0;
      for (int k = MAX_NREQ - 1; k >= 0; k--) begin
         if (k < nreq) begin
            idx = int'(ptr) + k;
            if (idx >= nreq) idx = idx - nreq;
            if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/en_reg_cell.sv
// rtl/en_reg_cell.sv - WIDTH-bit register with load enable
module en_reg_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Load on enable, otherwise hold; reset clears.
   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/en_reg_arbiter.sv
// rtl/en_reg_arbiter.sv - round-robin arbiter for a shared register bank write port
module en_reg_arbiter
   import en_reg_arbiter_pkg::*;
#(
   parameter int NREQ   = NREQ_D,
   parameter int NREG   = NREG_D,
   parameter int WIDTH  = WIDTH_D,
   parameter int ADDR_W = ADDR_W_D
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*ADDR_W-1:0]  waddr,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [NREG*WIDTH-1:0]   q_bank,
   output logic                    busy
);

   logic [2:0]          ptr;
   logic [MAX_NREQ-1:0] req_pad;
   logic [3:0]          pick;
   logic                commit;
   logic [ADDR_W-1:0]   gaddr;
   logic [WIDTH-1:0]    gdata;
   logic [NREG-1:0]     en;

   // Round-robin grant; reset masks every grant so nothing commits.
   always_comb begin
      req_pad           = '0;
      req_pad[NREQ-1:0] = req;
      pick              = rr_pick(req_pad, ptr, NREQ);
      gnt               = '0;
      for (int i = 0; i < NREQ; i++) begin
         gnt[i] = ~rst & pick[3] & (pick[2:0] == 3'(i));
      end
   end

   // Steer the granted requester's address and data onto the shared write port.
   always_comb begin
      commit = |gnt;
      gaddr  = '0;
      gdata  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gaddr = waddr[i*ADDR_W +: ADDR_W];
            gdata = wdata[i*WIDTH +: WIDTH];
         end
      end
   end

   // Address decode; addresses at or beyond NREG enable nothing and are dropped.
   always_comb begin
      en = '0;
      for (int r = 0; r < NREG; r++) begin
         en[r] = commit & (gaddr == ADDR_W'(r));
      end
   end

   // Pointer moves just past the winner on a commit; busy flags a commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= '0;
         busy <= 1'b0;
      end else begin
         busy <= commit;
         if (commit) ptr <= (pick[2:0] == 3'(NREQ - 1)) ? 3'd0 : pick[2:0] + 3'd1;
      end
   end

   genvar r;
   generate
      for (r = 0; r < NREG; r++) begin : g_bank
         en_reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (en[r]),
            .d   (gdata),
            .q   (q_bank[r*WIDTH +: WIDTH])
         );
      end
   endgenerate

endmodule

// File: doc/en_reg_arbiter.md
Name: en_reg_arbiter

Overview:
Shares the single write port of a bank of NREG enable-registers between NREQ requesters using round-robin arbitration. Each register is a WIDTH-bit D flip-flop with enable: it loads when enabled and holds otherwise. The arbiter selects at most one write per cycle and drives that register's enable and data. Every bank register is always readable on a flat output bus.

Parameters:
NREQ, 4, number of requesters (2..8)
NREG, 4, number of bank registers (1..16)
WIDTH, 8, data width of each bank register
ADDR_W, 2, register address width; must satisfy 2**ADDR_W >= NREG

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  reset, synchronous, active-high
req  input  NREQ  per-requester write request; level, held until granted
waddr  input  NREQ*ADDR_W  per-requester target register; slice i = bits [i*ADDR_W +: ADDR_W]
wdata  input  NREQ*WIDTH  per-requester write data; slice i = bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant, combinational from req and the priority pointer
q_bank  output  NREG*WIDTH  bank register contents; slice r = register r
busy  output  1  registered; 1 if any write was committed on the previous edge

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: all q_bank registers = 0, priority pointer ptr = 0, busy = 0.
- gnt is forced to 0 while rst = 1. Reset overrides any write in the same cycle.
- Arbitration (combinational):
  - Scan requesters ptr, ptr+1, ..., ptr+NREQ-1, all mod NREQ.
  - The first i with req[i] = 1 receives gnt[i] = 1; all other gnt bits are 0.
  - No requests -> gnt = 0.
- Handshake:
  - A write is committed on the rising edge where req[i] & gnt[i] = 1.
  - The requester samples gnt in that cycle. It deasserts req, or presents a new request, from the next cycle.
  - An ungranted requester must hold req, waddr and wdata stable. The arbiter drops nothing.
- Write path:
  - Granted waddr selects register r; en_r = 1 for that register only; d = the granted wdata.
  - All other registers have en = 0 and hold their value.
  - Latency: q_bank slice r shows the new value in the cycle after the grant cycle.
- Pointer update:
  - On a committed grant to i: ptr <= (i+1) mod NREQ.
  - No grant: ptr holds.
- Fairness: a continuously asserted request is granted within NREQ cycles.
- Out-of-range address (waddr >= NREG):
  - The request is still granted and ptr still advances.
  - No register is enabled, so the write is silently discarded.
- Same-address contention: requesters targeting the same register are serialized. The last granted value wins.
- busy <= |(req & gnt) on every non-reset edge.
- Reset mid-operation: a pending request is not granted during rst. After rst falls, arbitration restarts from ptr = 0.

Decomposition:
- Package en_reg_arbiter_pkg:
  - Default constants NREQ_D, NREG_D, WIDTH_D, ADDR_W_D.
  - A function that computes the round-robin winner index from req and ptr.
- Sub-module en_reg_cell (WIDTH):
  - Ports clk, rst, en, d[WIDTH], q[WIDTH].
  - Sync active-high reset to 0; q <= d when en, else holds.
  - Instantiated NREG times via generate.
- Arbiter logic, pointer register, address decode and busy live in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles while req=4'b1111 -> gnt=0 throughout; q_bank=0 and busy=0 after the first edge.
- Single write: req[2]=1, waddr[2]=1, wdata[2]=8'hA5, one cycle -> gnt=4'b0100 that cycle; next cycle q_bank reg1=8'hA5, busy=1, ptr=3.
- Round-robin: from ptr=0, req=4'b1111 held, each requester writing its own register with data 8'h10+i -> grants 0,1,2,3,0 on consecutive cycles; regs 0..3 = 10,11,12,13.
- Hold/stability: req[0]=1, req[1]=1, ptr=1 -> requester 1 is granted first; requester 0 gets gnt[0]=1 on the next cycle; reg0 updates one cycle after that.
- Out-of-range with NREG=3, ADDR_W=2: req[1]=1, waddr[1]=3, wdata[1]=8'hFF -> gnt[1]=1 and ptr=2; q_bank unchanged.
- Reset mid-stream: rst=1 while req=4'b0110 and ptr=2 -> no write commits; after rst falls with req unchanged, requester 1 is granted first (ptr=0).
